// File: rtl/cam_pkg.sv
// Shared definitions for the CAM request sequencer: op encoding, FSM states,
// default geometry and the reserved key.
package cam_pkg;

  localparam int CAM_NB_MEM = 16;
  localparam int CAM_DATA_W = 8;
  localparam int CAM_IDX_W  = 5;

  localparam logic OP_LOOKUP = 1'b0;
  localparam logic OP_INSERT = 1'b1;

  // Key 0 matches every cleared CAM slot, so it can never be stored or found.
  localparam logic [CAM_DATA_W-1:0] RESERVED_KEY = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOK,
    S_EVAL,
    S_WRITE,
    S_RESP
  } state_t;

endpackage

// File: rtl/cam_seq_stats.sv
// Saturating 16-bit event counters for the sequencer (hits, misses, insert
// errors). Only instantiated when CAM_SEQ_STATS_EN is defined.
module cam_seq_stats #(
  parameter int NUM_CNT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CNT-1:0]       inc,
  output logic [NUM_CNT-1:0][15:0] cnt
);

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    // One counter per event; holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
      if (!rst_n)
        cnt[g] <= '0;
      else if (inc[g] && (cnt[g] != 16'hFFFF))
        cnt[g] <= cnt[g] + 16'd1;
    end
  end

endmodule

// File: rtl/cam_seq.sv
// Request sequencer in front of a 16-entry CAM: turns lookup/insert commands
// into CAM enable/write pulses, owns slot allocation and returns one response
// per command. Optional statistics counters: define CAM_SEQ_STATS_EN.
module cam_seq
  import cam_pkg::*;
#(
  parameter int NB_MEM = CAM_NB_MEM,
  parameter int DATA_W = CAM_DATA_W,
  parameter int IDX_W  = CAM_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [IDX_W-1:0]  rsp_idx,
  output logic              rsp_err,
  output logic              cam_enable,
  output logic              cam_write,
  output logic [IDX_W-1:0]  cam_addr,
  output logic [DATA_W-1:0] cam_data,
  input  logic [IDX_W-1:0]  cam_out,
  input  logic              cam_found
`ifdef CAM_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_hits,
  output logic [15:0]       stat_misses,
  output logic [15:0]       stat_full
`endif
);

  // Fill pointer spans 0..NB_MEM inclusive so "full" is its own value.
  localparam int FILL_W = $clog2(NB_MEM + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NB_MEM);

  state_t             state, state_nxt;
  logic               op;
  logic [DATA_W-1:0]  key;
  logic [FILL_W-1:0]  fill;

  logic               accept, reserved;
  logic               en_nxt, wr_nxt, rv_nxt, hit_nxt, err_nxt;
  logic [IDX_W-1:0]   addr_nxt, idx_nxt;
  logic [DATA_W-1:0]  data_nxt;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_ready && req_valid;
  assign reserved  = (req_op == OP_INSERT) && (req_data == RESERVED_KEY);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; a miss on insert goes to WRITE only while slots remain.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = reserved ? S_RESP : S_LOOK;
      S_LOOK:  state_nxt = S_EVAL;
      S_EVAL:  state_nxt = ((op == OP_LOOKUP) || cam_found || (fill == FILL_MAX))
                           ? S_RESP : S_WRITE;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; CAM strobes are single-cycle pulses.
  always_comb begin
    en_nxt   = 1'b0;
    wr_nxt   = 1'b0;
    addr_nxt = cam_addr;
    data_nxt = cam_data;
    rv_nxt   = rsp_valid;
    hit_nxt  = rsp_hit;
    idx_nxt  = rsp_idx;
    err_nxt  = rsp_err;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          data_nxt = req_data;
          if (reserved) begin
            rv_nxt  = 1'b1;
            hit_nxt = 1'b0;
            idx_nxt = '0;
            err_nxt = 1'b1;
          end else begin
            en_nxt = 1'b1;
          end
        end
      end
      S_EVAL: begin
        if (op == OP_LOOKUP) begin
          // Key 0 would match every empty slot, so it always reports a miss.
          rv_nxt  = 1'b1;
          hit_nxt = cam_found && (key != RESERVED_KEY);
          idx_nxt = hit_nxt ? cam_out : '0;
          err_nxt = 1'b0;
        end else if (cam_found) begin
          rv_nxt  = 1'b1;
          hit_nxt = 1'b1;
          idx_nxt = cam_out;
          err_nxt = 1'b0;
        end else if (fill == FILL_MAX) begin
          rv_nxt  = 1'b1;
          hit_nxt = 1'b0;
          idx_nxt = '0;
          err_nxt = 1'b1;
        end else begin
          wr_nxt   = 1'b1;
          addr_nxt = IDX_W'(fill);
        end
      end
      S_WRITE: begin
        rv_nxt  = 1'b1;
        hit_nxt = 1'b0;
        idx_nxt = IDX_W'(fill);
        err_nxt = 1'b0;
      end
      S_RESP: if (rsp_ready) rv_nxt = 1'b0;
      default: ;
    endcase
  end

  // Output registers, command latches and the saturating fill pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op         <= OP_LOOKUP;
      key        <= '0;
      fill       <= '0;
      cam_enable <= 1'b0;
      cam_write  <= 1'b0;
      cam_addr   <= '0;
      cam_data   <= '0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_idx    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        op  <= req_op;
        key <= req_data;
      end
      if ((state == S_WRITE) && (fill != FILL_MAX))
        fill <= fill + 1'b1;
      cam_enable <= en_nxt;
      cam_write  <= wr_nxt;
      cam_addr   <= addr_nxt;
      cam_data   <= data_nxt;
      rsp_valid  <= rv_nxt;
      rsp_hit    <= hit_nxt;
      rsp_idx    <= idx_nxt;
      rsp_err    <= err_nxt;
    end
  end

`ifdef CAM_SEQ_STATS_EN
  logic             rsp_hs;
  logic [2:0]       stat_inc;
  logic [2:0][15:0] stat_cnt;

  assign rsp_hs   = rsp_valid && rsp_ready;
  assign stat_inc = {rsp_hs && (op == OP_INSERT) && rsp_err,
                     rsp_hs && (op == OP_LOOKUP) && !rsp_hit,
                     rsp_hs && (op == OP_LOOKUP) && rsp_hit};

  cam_seq_stats #(.NUM_CNT(3)) u_stats (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stat_inc),
    .cnt   (stat_cnt)
  );

  assign stat_hits   = stat_cnt[0];
  assign stat_misses = stat_cnt[1];
  assign stat_full   = stat_cnt[2];
`endif

endmodule

// File: tb/tb_cam_seq.sv
// Bench for cam_seq with a behavioural 16-entry CAM attached. Commands come
// from a vector table; expected responses go through a scoreboard queue.
module tb_cam_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_op;
  logic [7:0] req_data;
  logic       rsp_valid, rsp_ready, rsp_hit, rsp_err;
  logic [4:0] rsp_idx;
  logic       cam_enable, cam_write, cam_found;
  logic [4:0] cam_addr, cam_out;
  logic [7:0] cam_data;
`ifdef CAM_SEQ_STATS_EN
  logic [15:0] stat_hits, stat_misses, stat_full;
`endif

  always #5 clk = ~clk;

  cam_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx),
    .rsp_err(rsp_err),
    .cam_enable(cam_enable), .cam_write(cam_write), .cam_addr(cam_addr), .cam_data(cam_data),
    .cam_out(cam_out), .cam_found(cam_found)
`ifdef CAM_SEQ_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_full(stat_full)
`endif
  );

  // Behavioural CAM: registered lookup result, lowest matching slot wins.
  logic [7:0] cmem [16];

  function automatic logic [5:0] srch(input logic [7:0] k);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 15; i >= 0; i--)
      if (cmem[i] == k) r = {1'b1, 5'(i)};
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) cmem[i] <= 8'h00;
      cam_found <= 1'b0;
      cam_out   <= 5'd0;
    end else begin
      if (cam_write) cmem[cam_addr[3:0]] <= cam_data;
      if (cam_enable) {cam_found, cam_out} <= srch(cam_data);
    end
  end

  // Per-command CAM activity counters and strobe-overlap detector.
  int en_cnt, wr_cnt, overlap;
  always @(negedge clk) begin
    if (cam_enable) en_cnt++;
    if (cam_write)  wr_cnt++;
    if (cam_enable && cam_write) overlap++;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       op;
    logic [7:0] data;
    logic       hit;
    logic [4:0] idx;
    logic       err;
    int         lat;
    int         en;
    int         wr;
  } vec_t;

  vec_t sb[$];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_cmd(input string name, input vec_t v);
    vec_t e;
    int   lat;
    sb.push_back(v);
    @(negedge clk);
    en_cnt = 0; wr_cnt = 0;
    req_valid = 1'b1; req_op = v.op; req_data = v.data; rsp_ready = 1'b1;
    chk({name, ".req_ready"}, int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk({name, ".rsp_valid"}, int'(rsp_valid), 1);
    chk({name, ".hit"}, int'(rsp_hit), int'(e.hit));
    chk({name, ".idx"}, int'(rsp_idx), int'(e.idx));
    chk({name, ".err"}, int'(rsp_err), int'(e.err));
    chk({name, ".lat"}, lat, e.lat);
    chk({name, ".en"}, en_cnt, e.en);
    chk({name, ".wr"}, wr_cnt, e.wr);
    @(posedge clk); #1;
    chk({name, ".rsp_clr"}, int'(rsp_valid), 0);
  endtask

  localparam logic LK = 1'b0;
  localparam logic IN = 1'b1;

  vec_t tbl[8];

  initial begin
    vec_t v;
    logic       h_hit, h_err;
    logic [4:0] h_idx;
    int         bad, n;

    // {op, key, hit, idx, err, latency, enable pulses, write pulses}
    tbl[0] = '{IN, 8'hA5, 1'b0, 5'd0, 1'b0, 4, 1, 1};
    tbl[1] = '{LK, 8'hA5, 1'b1, 5'd0, 1'b0, 3, 1, 0};
    tbl[2] = '{IN, 8'hA5, 1'b1, 5'd0, 1'b0, 3, 1, 0};
    tbl[3] = '{IN, 8'h3C, 1'b0, 5'd1, 1'b0, 4, 1, 1};
    tbl[4] = '{LK, 8'h00, 1'b0, 5'd0, 1'b0, 3, 1, 0};
    tbl[5] = '{IN, 8'h00, 1'b0, 5'd0, 1'b1, 1, 0, 0};
    tbl[6] = '{LK, 8'h77, 1'b0, 5'd0, 1'b0, 3, 1, 0};
    tbl[7] = '{LK, 8'h3C, 1'b1, 5'd1, 1'b0, 3, 1, 0};

    req_valid = 1'b0; req_op = 1'b0; req_data = 8'h00; rsp_ready = 1'b1; rst_n = 1'b0;
    en_cnt = 0; wr_cnt = 0; overlap = 0;
    do_reset();

    // Reset state
    #1;
    chk("rst.req_ready",  int'(req_ready), 1);
    chk("rst.rsp_valid",  int'(rsp_valid), 0);
    chk("rst.rsp_hit",    int'(rsp_hit), 0);
    chk("rst.rsp_err",    int'(rsp_err), 0);
    chk("rst.rsp_idx",    int'(rsp_idx), 0);
    chk("rst.cam_enable", int'(cam_enable), 0);
    chk("rst.cam_write",  int'(cam_write), 0);
    chk("rst.cam_addr",   int'(cam_addr), 0);
    chk("rst.cam_data",   int'(cam_data), 0);

    for (int i = 0; i < 8; i++) do_cmd($sformatf("tbl%0d", i), tbl[i]);

    // Fill every slot, then overflow
    do_reset();
    for (int k = 1; k <= 16; k++)
      do_cmd($sformatf("fill%0d", k), '{IN, 8'(k), 1'b0, 5'(k - 1), 1'b0, 4, 1, 1});
    do_cmd("full_ins", '{IN, 8'h11, 1'b0, 5'd0, 1'b1, 3, 1, 0});
    do_cmd("full_dup", '{IN, 8'h07, 1'b1, 5'd6, 1'b0, 3, 1, 0});
    do_cmd("lk_last",  '{LK, 8'h10, 1'b1, 5'd15, 1'b0, 3, 1, 0});
    do_cmd("lk_first", '{LK, 8'h01, 1'b1, 5'd0, 1'b0, 3, 1, 0});

    // Response back-pressure: outputs frozen, no new command, CAM idle
    do_reset();
    do_cmd("bp_ins", '{IN, 8'h5A, 1'b0, 5'd0, 1'b0, 4, 1, 1});
    @(negedge clk);
    req_valid = 1'b1; req_op = LK; req_data = 8'h5A; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp.rsp_valid", int'(rsp_valid), 1);
    h_hit = rsp_hit; h_idx = rsp_idx; h_err = rsp_err;
    chk("bp.hit", int'(h_hit), 1);
    chk("bp.idx", int'(h_idx), 0);
    chk("bp.err", int'(h_err), 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bad = 0;
      if (!rsp_valid || rsp_hit != h_hit || rsp_idx != h_idx || rsp_err != h_err) bad++;
      if (req_ready || cam_enable || cam_write) bad++;
      chk($sformatf("bp.hold%0d", c), bad, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_valid", int'(rsp_valid), 0);
    chk("bp.release_ready", int'(req_ready), 1);

    // Reset landing on the WRITE cycle drops the command and the write
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_op = IN; req_data = 8'h33; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("wrst.in_write", int'(cam_write), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("wrst.rsp_valid", int'(rsp_valid), 0);
    chk("wrst.req_ready", int'(req_ready), 1);
    chk("wrst.cam_write", int'(cam_write), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd("wrst.lk",  '{LK, 8'h33, 1'b0, 5'd0, 1'b0, 3, 1, 0});
    do_cmd("wrst.ins", '{IN, 8'h44, 1'b0, 5'd0, 1'b0, 4, 1, 1});

    chk("en_wr_overlap", overlap, 0);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cam_seq.md
Name: cam_seq

Overview:
- Request sequencer directly upstream of the 16-entry content-addressable memory (CAM) block.
- Accepts lookup/insert commands on a valid/ready handshake and drives the CAM control pins (enable, write, addr, data).
- Samples the CAM's registered found/out result and returns one response per command on a valid/ready handshake.
- Owns slot allocation: sequential fill pointer, duplicate suppression, full detection.

Parameters:
- NB_MEM, 16, number of CAM entries; must match the CAM instance.
- DATA_W, 8, key width.
- IDX_W, 5, CAM index/addr width; MSB always driven 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- req_valid  in  1  command valid
- req_ready  out  1  high only in IDLE
- req_op  in  1  0=lookup, 1=insert
- req_data  in  DATA_W  key
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_hit  out  1  key present in CAM
- rsp_idx  out  IDX_W  matching or newly written slot
- rsp_err  out  1  insert rejected (full or reserved key)
- cam_enable  out  1  to CAM enable
- cam_write  out  1  to CAM write
- cam_addr  out  IDX_W  to CAM addr
- cam_data  out  DATA_W  to CAM data
- cam_out  in  IDX_W  from CAM out
- cam_found  in  1  from CAM found

Behaviour:
- States: IDLE, LOOK, EVAL, WRITE, RESP. All state and outputs are registered.
- Reset (rst_n low at a clk edge):
  - state=IDLE, fill=0, key/op latches=0.
  - rsp_valid/rsp_hit/rsp_err=0, rsp_idx=0.
  - cam_enable/cam_write=0, cam_addr=0, cam_data=0.
  - Overrides any in-flight command; the command is dropped with no response. The CAM shares rst_n and clears its contents too.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op and data, then go to LOOK.
  - Reserved-key case: insert with req_data==0 goes straight to RESP with err=1, hit=0, idx=0. Zero is the CAM's reset fill value.
- LOOK:
  - cam_enable=1, cam_data=latched key.
  - Go to EVAL.
- EVAL:
  - cam_found/cam_out are valid this cycle (CAM result registered at the LOOK edge).
  - Lookup: go to RESP with hit=cam_found, idx=cam_found?cam_out:0.
  - Lookup of key 0: forced miss (hit=0, idx=0) regardless of cam_found.
  - Insert with cam_found=1: go to RESP, hit=1, idx=cam_out, no write (duplicate).
  - Insert, miss, fill==NB_MEM: go to RESP, err=1, hit=0, idx=0.
  - Insert, miss, fill<NB_MEM: go to WRITE.
- WRITE:
  - cam_write=1, cam_enable=0, cam_addr={0,fill[3:0]}, cam_data=key.
  - The CAM accepts the write because its ret was cleared by the preceding miss.
  - fill<=fill+1. Go to RESP with hit=0, idx=old fill.
- RESP:
  - rsp_valid=1; rsp_* stable until rsp_ready.
  - On rsp_ready, go to IDLE and clear rsp_valid.
  - req_ready=0 throughout, so only one command is outstanding.
- cam_enable and cam_write are never high together. cam_data holds the latched key outside IDLE.
- Latency, accept edge to rsp_valid: lookup 3 cycles, insert-hit/full 3, insert-new 4, reserved key 1.
- fill is 5 bits (0..NB_MEM), saturates at NB_MEM and never wraps. The table only clears via reset.

Optional Feature:
- Macro CAM_SEQ_STATS_EN.
- Defined: adds outputs stat_hits[15:0], stat_misses[15:0], stat_full[15:0].
  - Counters increment on the RESP handshake for lookup hit, lookup miss, and insert err respectively.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package cam_pkg:
  - op encoding: OP_LOOKUP=1'b0, OP_INSERT=1'b1
  - state enum
  - NB_MEM, DATA_W, IDX_W defaults
  - RESERVED_KEY=8'h00
- Sub-module: cam_seq_stats (saturating counter bank), instantiated only under CAM_SEQ_STATS_EN.
- Bench instantiates cam_seq plus the real CAM.

Test Plan:
- Reset, insert 8'hA5 -> rsp after 4 cycles: hit=0, idx=0, err=0; then lookup A5 -> hit=1, idx=0 after 3 cycles.
- Insert A5 twice -> second rsp hit=1, idx=0, no cam_write pulse, fill stays 1.
- Insert keys 1..16 -> idx 0..15; insert 8'h11 -> err=1; lookup 8'h10 -> hit=1, idx=15.
- Lookup 8'h00 and insert 8'h00 after reset -> lookup hit=0; insert err=1 in 1 cycle, no cam_enable pulse.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_* stable, req_ready=0, no CAM activity.
- Assert rst_n=0 in WRITE -> next edge IDLE, no rsp_valid, fill=0; subsequent lookup of that key -> hit=0.
